// File: rtl/refill_arbiter.sv
// refill_arbiter: shares one AXI read master port between N_REQ cache refill requesters.
// Round-robin grant by default; define ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module refill_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_REQ-1:0]        s_req_i,
    input  logic [N_REQ*ADDR_W-1:0] s_addr_i,
    output logic [N_REQ-1:0]        s_wait_o,
    output logic [N_REQ-1:0]        s_out_valid_o,
    output logic [31:0]             s_out_o,
    output logic                    m_req_o,
    output logic [ADDR_W-1:0]       m_addr_o,
    input  logic                    m_wait_i,
    input  logic                    m_out_valid_i,
    input  logic [31:0]             m_out_i
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;

    logic [1:0]        state_q;
    logic [N_REQ-1:0]  pend_q;
    logic [ADDR_W-1:0] addr_q [N_REQ];
    logic [IDX_W-1:0]  owner_q;
    logic [N_REQ-1:0]  owns;
    logic [N_REQ-1:0]  accept;
    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;

    assign m_req_o = (state_q == ST_ISSUE);
    assign s_out_o = m_out_i;

    for (genvar g = 0; g < N_REQ; g++) begin : g_port
        logic is_owner;
        assign is_owner  = (owner_q == IDX_W'(g));
        assign owns[g]   = is_owner && (state_q != ST_IDLE);
        // A request while already pending or while owning the port is dropped.
        assign accept[g] = s_req_i[g] && !pend_q[g] && !owns[g];
        assign s_wait_o[g] = pend_q[g] |
                             (is_owner && ((state_q == ST_ISSUE) ||
                                           ((state_q == ST_XFER) && (m_wait_i || m_out_valid_i))));
        assign s_out_valid_o[g] = is_owner && (state_q == ST_XFER) && m_out_valid_i;

        a_no_dup_req: assert property (@(posedge clk_i) disable iff (rst_i)
                                       !(s_req_i[g] && (pend_q[g] || owns[g])));
    end

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] last_q;

    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int step);
        return IDX_W'((int'(base) + step) % N_REQ);
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        // Walk from the farthest candidate to the nearest so last+1 wins ties.
        for (int k = N_REQ; k >= 1; k--) begin
            if (pend_q[rr_index(last_q, k)]) begin
                grant_valid = 1'b1;
                grant_idx   = rr_index(last_q, k);
            end
        end
    end
`endif

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            pend_q   <= '0;
            owner_q  <= '0;
            m_addr_o <= '0;
            // NOTE: the address store is small and its reset value is visible, so it is cleared too.
            for (int i = 0; i < N_REQ; i++) addr_q[i] <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last_q   <= IDX_W'(N_REQ - 1);
`endif
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (accept[i]) begin
                    pend_q[i] <= 1'b1;
                    addr_q[i] <= s_addr_i[i*ADDR_W +: ADDR_W];
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner_q           <= grant_idx;
                        pend_q[grant_idx] <= 1'b0;
                        m_addr_o          <= addr_q[grant_idx];
                        state_q           <= ST_ISSUE;
`ifndef ARB_FIXED_PRIO_EN
                        last_q            <= grant_idx;
`endif
                    end
                end
                ST_ISSUE: state_q <= ST_XFER;
                ST_XFER: begin
                    if (!m_wait_i && !m_out_valid_i) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_refill_arbiter.sv
// tb_refill_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// Define ARB_FIXED_PRIO_EN on both files to check the fixed-priority build.
module tb_refill_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [N-1:0]    s_req_i;
    logic [N*AW-1:0] s_addr_i;
    logic [N-1:0]    s_wait_o;
    logic [N-1:0]    s_out_valid_o;
    logic [31:0]     s_out_o;
    logic            m_req_o;
    logic [AW-1:0]   m_addr_o;
    logic            m_wait_i;
    logic            m_out_valid_i;
    logic [31:0]     m_out_i;

    int checks = 0;
    int errors = 0;

    int         obs_beats [N];
    int         obs_cycles;
    int         obs_watch_high;
    int         obs_owner_low;
    int         obs_data_bad;
    logic [N-1:0] obs_final_wait;

    refill_arbiter #(.N_REQ(N), .ADDR_W(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_req_i(s_req_i), .s_addr_i(s_addr_i),
        .s_wait_o(s_wait_o), .s_out_valid_o(s_out_valid_o), .s_out_o(s_out_o),
        .m_req_o(m_req_o), .m_addr_o(m_addr_o),
        .m_wait_i(m_wait_i), .m_out_valid_i(m_out_valid_i), .m_out_i(m_out_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Inputs change 1 time unit after the rising edge; pulses last one cycle.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
        s_req_i       = '0;
        m_out_valid_i = 1'b0;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic set_req(input int i, input logic [31:0] a);
        s_req_i[i]            = 1'b1;
        s_addr_i[i*AW +: AW]  = a;
    endtask

    task automatic apply_reset();
        rst_i    = 1'b1;
        m_wait_i = 1'b0;
        repeat (2) next_cycle();
        rst_i = 1'b0;
    endtask

    task automatic wait_mreq(output bit found);
        found = 1'b0;
        for (int n = 0; n < 30 && !found; n++) begin
            next_cycle();
            sample();
            if (m_req_o) found = 1'b1;
        end
    endtask

    task automatic record(input int owner, input int watch, input bit armed, input bit done);
        for (int j = 0; j < N; j++) obs_beats[j] += int'(s_out_valid_o[j]);
        if (s_out_o !== m_out_i) obs_data_bad++;
        if (!done && !s_wait_o[owner]) obs_owner_low++;
        if (armed && watch >= 0) begin
            obs_cycles++;
            if (s_wait_o[watch]) obs_watch_high++;
        end
        if (done) obs_final_wait = s_wait_o;
    endtask

    // Master side of one transfer starting the cycle after m_req_o; ends after sampling completion.
    task automatic master_xfer(input int nbeats, input logic [31:0] base, input int owner,
                               input int watch, input int late_beat, input logic [31:0] late_addr);
        for (int j = 0; j < N; j++) obs_beats[j] = 0;
        obs_cycles = 0; obs_watch_high = 0; obs_owner_low = 0; obs_data_bad = 0;
        next_cycle();
        m_wait_i = 1'b1;
        sample();
        record(owner, watch, late_beat < 0, 1'b0);
        for (int b = 0; b < nbeats; b++) begin
            next_cycle();
            m_out_valid_i = 1'b1;
            m_out_i       = base + 32'(b);
            if (b == late_beat) set_req(watch, late_addr);
            sample();
            record(owner, watch, late_beat < 0 || b > late_beat, 1'b0);
        end
        next_cycle();
        m_wait_i = 1'b0;
        sample();
        record(owner, watch, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; s_req_i = '0; s_addr_i = '0;
        m_wait_i = 1'b0; m_out_valid_i = 1'b0; m_out_i = 32'h0;
        repeat (2) next_cycle();
        m_out_i = 32'hDEAD_BEEF;
        sample();
        checks++; if (m_req_o !== 1'b0) begin errors++; $display("FAIL reset_m_req got=%b exp=0", m_req_o); end
        checks++; if (m_addr_o !== '0) begin errors++; $display("FAIL reset_m_addr got=%h exp=0", m_addr_o); end
        checks++; if (s_wait_o !== '0) begin errors++; $display("FAIL reset_s_wait got=%b exp=0", s_wait_o); end
        checks++; if (s_out_valid_o !== '0) begin errors++; $display("FAIL reset_s_out_valid got=%b exp=0", s_out_valid_o); end
        checks++; if (s_out_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL reset_s_out got=%h exp=deadbeef", s_out_o); end
        next_cycle();
        rst_i = 1'b0;
    endtask

    task automatic test_single_refill();
        next_cycle();
        set_req(0, 32'h0000_1230);
        sample();
        checks++; if (s_wait_o !== 3'b000) begin errors++; $display("FAIL single_c0_wait got=%b exp=000", s_wait_o); end
        next_cycle(); sample();
        checks++; if (s_wait_o !== 3'b001) begin errors++; $display("FAIL single_c1_wait got=%b exp=001", s_wait_o); end
        checks++; if (m_req_o !== 1'b0) begin errors++; $display("FAIL single_c1_m_req got=%b exp=0", m_req_o); end
        next_cycle(); sample();
        checks++; if (m_req_o !== 1'b1) begin errors++; $display("FAIL single_c2_m_req got=%b exp=1", m_req_o); end
        checks++; if (m_addr_o !== 32'h0000_1230) begin errors++; $display("FAIL single_m_addr got=%h exp=00001230", m_addr_o); end
        master_xfer(4, 32'hA0, 0, 1, -1, 32'h0);
        checks++; if (obs_beats[0] !== 4) begin errors++; $display("FAIL single_beats0 got=%0d exp=4", obs_beats[0]); end
        checks++; if (obs_watch_high !== 0) begin errors++; $display("FAIL single_wait1_high got=%0d exp=0", obs_watch_high); end
        checks++; if (obs_owner_low !== 0) begin errors++; $display("FAIL single_wait0_early_low got=%0d exp=0", obs_owner_low); end
        checks++; if (obs_final_wait !== 3'b000) begin errors++; $display("FAIL single_wait_at_done got=%b exp=000", obs_final_wait); end
        checks++; if (obs_data_bad !== 0) begin errors++; $display("FAIL single_data got=%0d bad exp=0", obs_data_bad); end
        next_cycle(); sample();
        checks++; if (m_req_o !== 1'b0 || s_wait_o !== 3'b000) begin
            errors++; $display("FAIL single_idle_after got=%b/%b exp=0/000", m_req_o, s_wait_o);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        next_cycle();
        set_req(0, 32'h100);
        set_req(1, 32'h200);
        sample();
        next_cycle(); sample();
        checks++; if (s_wait_o !== 3'b011) begin errors++; $display("FAIL cont_wait got=%b exp=011", s_wait_o); end
        next_cycle(); sample();
        checks++; if (m_req_o !== 1'b1 || m_addr_o !== 32'h100) begin
            errors++; $display("FAIL cont_first_grant got=%b/%h exp=1/100", m_req_o, m_addr_o);
        end
        master_xfer(3, 32'hB0, 0, 1, -1, 32'h0);
        checks++; if (obs_watch_high !== obs_cycles) begin
            errors++; $display("FAIL cont_wait1_held got=%0d exp=%0d", obs_watch_high, obs_cycles);
        end
        checks++; if (obs_beats[0] !== 3 || obs_beats[1] !== 0) begin
            errors++; $display("FAIL cont_beats got=%0d/%0d exp=3/0", obs_beats[0], obs_beats[1]);
        end
        next_cycle(); sample();
        checks++; if (m_req_o !== 1'b0) begin errors++; $display("FAIL cont_done_plus1 got=%b exp=0", m_req_o); end
        next_cycle(); sample();
        checks++; if (m_req_o !== 1'b1 || m_addr_o !== 32'h200) begin
            errors++; $display("FAIL cont_second_grant got=%b/%h exp=1/200", m_req_o, m_addr_o);
        end
        master_xfer(2, 32'hC0, 1, -1, -1, 32'h0);
        checks++; if (obs_beats[1] !== 2 || obs_beats[0] !== 0) begin
            errors++; $display("FAIL cont_beats2 got=%0d/%0d exp=2/0", obs_beats[1], obs_beats[0]);
        end
    endtask

    // Each requester re-requests the cycle after its own completion; grants alternate.
    task automatic test_fairness();
        bit found;
        int exp_owner;
        logic [31:0] exp_addr;
        next_cycle();
        set_req(0, 32'h1000);
        set_req(1, 32'h2000);
        sample();
        for (int r = 0; r < 4; r++) begin
            exp_owner = r % 2;
            exp_addr  = ((exp_owner == 0) ? 32'h1000 : 32'h2000) + 32'((r / 2) * 16);
            wait_mreq(found);
            checks++; if (!found) begin errors++; $display("FAIL fair_timeout round=%0d got=none exp=m_req", r); end
            checks++; if (m_addr_o !== exp_addr) begin
                errors++; $display("FAIL fair_order round=%0d got=%h exp=%h", r, m_addr_o, exp_addr);
            end
            master_xfer(2, 32'hE0, exp_owner, -1, -1, 32'h0);
            if (r < 2) begin
                next_cycle();
                set_req(exp_owner, exp_addr + 32'h10);
                sample();
            end
        end
    endtask

    task automatic test_rr_pointer();
        bit found;
`ifdef ARB_FIXED_PRIO_EN
        int first = 0, second = 2;
`else
        int first = 2, second = 0;
`endif
        next_cycle();
        set_req(0, 32'h6000);
        set_req(2, 32'h6200);
        sample();
        wait_mreq(found);
        checks++; if (!found || m_addr_o !== 32'h6000 + 32'(first * 'h100)) begin
            errors++; $display("FAIL rr_first got=%b/%h exp=1/%h", found, m_addr_o, 32'h6000 + 32'(first * 'h100));
        end
        master_xfer(1, 32'h11, first, -1, -1, 32'h0);
        checks++; if (obs_beats[first] !== 1) begin errors++; $display("FAIL rr_first_beat got=%0d exp=1", obs_beats[first]); end
        wait_mreq(found);
        checks++; if (!found || m_addr_o !== 32'h6000 + 32'(second * 'h100)) begin
            errors++; $display("FAIL rr_second got=%b/%h exp=1/%h", found, m_addr_o, 32'h6000 + 32'(second * 'h100));
        end
        master_xfer(1, 32'h22, second, -1, -1, 32'h0);
    endtask

    task automatic test_late_request();
        bit found;
        next_cycle();
        set_req(0, 32'h7000);
        sample();
        wait_mreq(found);
        checks++; if (!found || m_addr_o !== 32'h7000) begin
            errors++; $display("FAIL late_grant0 got=%b/%h exp=1/7000", found, m_addr_o);
        end
        master_xfer(4, 32'hD0, 0, 1, 1, 32'h3000);
        checks++; if (obs_beats[0] !== 4 || obs_beats[1] !== 0) begin
            errors++; $display("FAIL late_beats got=%0d/%0d exp=4/0", obs_beats[0], obs_beats[1]);
        end
        checks++; if (obs_watch_high !== obs_cycles) begin
            errors++; $display("FAIL late_wait1_latched got=%0d exp=%0d", obs_watch_high, obs_cycles);
        end
        checks++; if (obs_data_bad !== 0) begin errors++; $display("FAIL late_data got=%0d bad exp=0", obs_data_bad); end
        next_cycle(); next_cycle(); sample();
        checks++; if (m_req_o !== 1'b1 || m_addr_o !== 32'h3000) begin
            errors++; $display("FAIL late_grant1 got=%b/%h exp=1/3000", m_req_o, m_addr_o);
        end
        master_xfer(1, 32'h33, 1, -1, -1, 32'h0);
        checks++; if (obs_beats[1] !== 1) begin errors++; $display("FAIL late_beats1 got=%0d exp=1", obs_beats[1]); end
    endtask

    task automatic test_reset_mid_xfer();
        bit found;
        int stray;
        next_cycle();
        set_req(0, 32'h4000);
        sample();
        wait_mreq(found);
        next_cycle();
        m_wait_i = 1'b1;
        set_req(1, 32'h5000);
        sample();
        repeat (2) begin
            next_cycle();
            m_out_valid_i = 1'b1;
            m_out_i       = 32'h55;
            sample();
        end
        next_cycle();
        rst_i    = 1'b1;
        m_wait_i = 1'b0;
        sample();
        next_cycle();
        rst_i         = 1'b0;
        m_out_valid_i = 1'b1;
        sample();
        checks++; if (m_req_o !== 1'b0 || m_addr_o !== '0) begin
            errors++; $display("FAIL rstx_master got=%b/%h exp=0/0", m_req_o, m_addr_o);
        end
        checks++; if (s_wait_o !== '0) begin errors++; $display("FAIL rstx_wait got=%b exp=000", s_wait_o); end
        checks++; if (s_out_valid_o !== '0) begin errors++; $display("FAIL rstx_valid got=%b exp=000", s_out_valid_o); end
        stray = 0;
        repeat (6) begin
            next_cycle(); sample();
            if (m_req_o || s_wait_o != '0) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL rstx_pend_dropped got=%0d active cycles exp=0", stray); end
    endtask

    // Transaction model: requesters become eligible the cycle after their pulse, the port is free
    // again the cycle after completion, and each grant shows m_req_o one cycle later.
    task automatic test_random();
        bit          act [N];
        bit          granted [N];
        int          rq_cyc [N];
        logic [31:0] rq_addr [N];
        int          last_m, free_from, mreq_due, cur_owner, beats_left, w, c;
        bit          port_busy, mst_start, mst_active, completion;
        logic [31:0] exp_addr, a;
        logic [N-1:0] exp_wait, exp_valid;
        apply_reset();
        for (int i = 0; i < N; i++) begin act[i] = 0; granted[i] = 0; rq_cyc[i] = 0; rq_addr[i] = 0; end
        last_m = N - 1; free_from = 0; mreq_due = -10; cur_owner = 0; beats_left = 0;
        port_busy = 0; mst_start = 0; mst_active = 0; exp_addr = 0;
        for (int t = 0; t < 600; t++) begin
            next_cycle();
            completion = 0;
            m_out_i = $urandom;
            if (mst_start) begin
                m_wait_i = 1'b1; beats_left = $urandom_range(1, 4);
                mst_start = 0; mst_active = 1;
            end else if (mst_active) begin
                if (beats_left > 0) begin
                    if ($urandom_range(0, 2) != 0) begin m_out_valid_i = 1'b1; beats_left--; end
                end else begin
                    m_wait_i = 1'b0; mst_active = 0; completion = 1;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!act[i] && $urandom_range(0, 3) == 0) begin
                    a = $urandom;
                    set_req(i, a);
                    act[i] = 1; granted[i] = 0; rq_cyc[i] = t; rq_addr[i] = a;
                end
            end
            if (completion) begin act[cur_owner] = 0; port_busy = 0; free_from = t + 1; end
            if (!port_busy && t >= free_from) begin
                w = -1;
                for (int k = 1; k <= N; k++) begin
`ifdef ARB_FIXED_PRIO_EN
                    c = k - 1;
`else
                    c = (last_m + k) % N;
`endif
                    if (w < 0 && act[c] && !granted[c] && rq_cyc[c] < t) w = c;
                end
                if (w >= 0) begin
                    granted[w] = 1; last_m = w; cur_owner = w; exp_addr = rq_addr[w];
                    mreq_due = t + 1; port_busy = 1;
                end
            end
            for (int i = 0; i < N; i++) exp_wait[i] = act[i] && rq_cyc[i] < t;
            exp_valid = m_out_valid_i ? N'(1 << cur_owner) : '0;
            sample();
            checks++; if (m_req_o !== (t == mreq_due)) begin
                errors++; $display("FAIL rand_m_req t=%0d got=%b exp=%b", t, m_req_o, t == mreq_due);
            end
            if (t == mreq_due) begin
                checks++; if (m_addr_o !== exp_addr) begin
                    errors++; $display("FAIL rand_m_addr t=%0d got=%h exp=%h", t, m_addr_o, exp_addr);
                end
                mst_start = 1;
            end
            checks++; if (s_wait_o !== exp_wait) begin
                errors++; $display("FAIL rand_s_wait t=%0d got=%b exp=%b", t, s_wait_o, exp_wait);
            end
            checks++; if (s_out_valid_o !== exp_valid) begin
                errors++; $display("FAIL rand_s_out_valid t=%0d got=%b exp=%b", t, s_out_valid_o, exp_valid);
            end
            checks++; if (s_out_o !== m_out_i) begin
                errors++; $display("FAIL rand_s_out t=%0d got=%h exp=%h", t, s_out_o, m_out_i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_refill();
        test_contention();
        test_fairness();
        test_rr_pointer();
        test_late_request();
        test_reset_mid_xfer();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
